// File: rtl/seg7_scan_drv_if.sv
// Bus between the BCD counter chain / board pins and the 7-segment scan driver.
// The master side feeds snapshot inputs; the slave side (the driver) returns display outputs.
interface seg7_scan_drv_if #(
   parameter int DIGITS = 4
);
   logic                  LATCH;
   logic [4*DIGITS-1:0]   BCD_IN;
   logic                  OVF;
   logic [7:0]            SEG;
   logic [DIGITS-1:0]     DIG;
   logic                  SCAN_TICK;

   modport master (
      output LATCH, BCD_IN, OVF,
      input  SEG, DIG, SCAN_TICK
   );

   modport slave (
      input  LATCH, BCD_IN, OVF,
      output SEG, DIG, SCAN_TICK
   );
endinterface

// File: rtl/seg7_scan_drv.sv
// Snapshot-and-scan driver for a multiplexed 7-segment display fed by BCD counters.
// Optional leading-zero blanking is enabled by defining SEG7_SCAN_LZB_EN.
module seg7_scan_drv #(
   parameter int DIGITS   = 4,
   parameter int SCAN_DIV = 1000
) (
   input logic            CLK,
   input logic            RST,
   seg7_scan_drv_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   logic [PW-1:0]         r_presc;
   logic [IW-1:0]         r_idx;
   logic [4*DIGITS-1:0]   r_snap;
   logic                  r_ovf;
   logic [7:0]            r_seg;
   logic [DIGITS-1:0]     r_dig;
   logic                  r_tick;

   logic                  w_wrap;
   logic [3:0]            w_nib;
   logic                  w_blank;
   logic [DIGITS-1:0]     w_dig;
   logic [DIGITS-1:0]     w_lz;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         default: seg_decode = 7'h40;
      endcase
   endfunction

   assign w_wrap = (r_presc == PW'(SCAN_DIV - 1));

   // NOTE: every variable gets a default before the loop so no latch is inferred.
   always_comb begin
      w_nib   = 4'd0;
      w_dig   = '1;
      w_lz    = '0;
      w_blank = 1'b0;
      w_lz[DIGITS-1] = (r_snap[4*DIGITS-1 -: 4] == 4'd0);
      for (int i = DIGITS - 2; i >= 0; i--) begin
         w_lz[i] = w_lz[i+1] && (r_snap[i*4 +: 4] == 4'd0);
      end
      for (int i = 0; i < DIGITS; i++) begin
         if (r_idx == IW'(i)) begin
            w_nib    = r_snap[i*4 +: 4];
            w_dig[i] = 1'b0;
`ifdef SEG7_SCAN_LZB_EN
            w_blank  = (i != 0) && w_lz[i];
`else
            w_blank  = 1'b0;
`endif
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so every register
   // samples pre-edge values; a LATCH on the wrap edge pairs new index with new snapshot.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_presc <= '0;
         r_idx   <= '0;
         r_snap  <= '0;
         r_ovf   <= 1'b0;
         r_seg   <= 8'h00;
         r_dig   <= '1;
         r_tick  <= 1'b0;
      end else begin
         if (bus.LATCH) begin
            r_snap <= bus.BCD_IN;
            r_ovf  <= bus.OVF;
         end
         r_presc <= w_wrap ? '0 : r_presc + PW'(1);
         if (w_wrap) begin
            r_idx <= (r_idx == IW'(DIGITS - 1)) ? '0 : r_idx + IW'(1);
         end
         r_tick <= w_wrap;
         r_dig  <= w_dig;
         r_seg  <= {r_ovf, (w_blank ? 7'h00 : seg_decode(w_nib))};
      end
   end

   assign bus.SEG       = r_seg;
   assign bus.DIG       = r_dig;
   assign bus.SCAN_TICK = r_tick;
endmodule

// File: tb/tb_seg7_scan_drv.sv
// Directed bench for seg7_scan_drv with DIGITS=4, SCAN_DIV=4; follows the
// expected scan position by counting clock edges since reset release.
module tb_seg7_scan_drv;
   logic CLK = 1'b0;
   logic RST;
   int   vectors = 0;
   int   miscompares = 0;
   int   n = 0;

   seg7_scan_drv_if #(.DIGITS(4)) bus ();

   seg7_scan_drv #(.DIGITS(4), .SCAN_DIV(4)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, n);
      end
   endtask

   // one rising edge, then settle before sampling
   task automatic clk1();
      @(posedge CLK);
      #1;
      n++;
   endtask

   function automatic int out_idx();
      return ((n - 1) / 4) % 4;
   endfunction

   function automatic logic [3:0] dig_of(input int idx);
      logic [3:0] d;
      d = 4'b1111;
      d[idx] = 1'b0;
      return d;
   endfunction

   task automatic latch_pulse(input logic [15:0] bcd, input logic ovf);
      bus.BCD_IN = bcd;
      bus.OVF    = ovf;
      bus.LATCH  = 1'b1;
      clk1();
      bus.LATCH  = 1'b0;
      clk1();
   endtask

   task automatic check_scan(input string tag, input logic [3:0][7:0] e);
      for (int k = 0; k < 16; k++) begin
         clk1();
         check({tag, "_seg"}, 32'(bus.SEG), 32'(e[out_idx()]));
         check({tag, "_dig"}, 32'(bus.DIG), 32'(dig_of(out_idx())));
         check({tag, "_tick"}, 32'(bus.SCAN_TICK), 32'((n % 4) == 0));
      end
   endtask

   initial begin
      logic [3:0][7:0] e;
      RST        = 1'b1;
      bus.LATCH  = 1'b0;
      bus.BCD_IN = 16'h0000;
      bus.OVF    = 1'b0;

      // reset state
      repeat (2) @(posedge CLK);
      #1;
      check("rst_seg", 32'(bus.SEG), 32'h00);
      check("rst_dig", 32'(bus.DIG), 32'hF);
      check("rst_tick", 32'(bus.SCAN_TICK), 32'h0);

      // release: first edge shows digit 0 of a zero snapshot
      RST = 1'b0;
      n = 0;
      clk1();
      check("rel_dig", 32'(bus.DIG), 32'b1110);
      check("rel_seg", 32'(bus.SEG), 32'h3F);
      check("rel_tick", 32'(bus.SCAN_TICK), 32'h0);
      e = {8'h3F, 8'h3F, 8'h3F, 8'h3F};
      check_scan("zero", e);

      // 1907: d0=7, d1=0, d2=9, d3=1
      latch_pulse(16'h1907, 1'b0);
      e = {8'h06, 8'h6F, 8'h3F, 8'h07};
      check_scan("1907", e);

      // 0A00 with overflow: d2 shows dash, dp on every digit
      latch_pulse(16'h0A00, 1'b1);
      e = {8'hBF, 8'hC0, 8'hBF, 8'hBF};
      check_scan("0A00_ovf", e);

      // dp clears two edges after LATCH with OVF=0
      bus.OVF   = 1'b0;
      bus.LATCH = 1'b1;
      clk1();
      bus.LATCH = 1'b0;
      check("dp_hold", 32'(bus.SEG[7]), 32'h1);
      clk1();
      check("dp_clear", 32'(bus.SEG[7]), 32'h0);

      // nibbles 10..15 all decode to dash
      latch_pulse(16'hFEDC, 1'b0);
      e = {8'h40, 8'h40, 8'h40, 8'h40};
      check_scan("hex", e);

      // live display with LATCH held, then change BCD_IN exactly on a wrap edge
      bus.BCD_IN = 16'h1111;
      bus.LATCH  = 1'b1;
      clk1();
      clk1();
      while (((n + 1) % 4) != 0) clk1();
      check("pre_wrap_seg", 32'(bus.SEG), 32'h06);
      bus.BCD_IN = 16'h2222;
      clk1();
      bus.LATCH = 1'b0;
      check("wrap_tick", 32'(bus.SCAN_TICK), 32'h1);
      check("wrap_old_seg", 32'(bus.SEG), 32'h06);
      clk1();
      check("wrap_new_seg", 32'(bus.SEG), 32'h5B);
      check("wrap_new_dig", 32'(bus.DIG), 32'(dig_of(out_idx())));

      // reset mid-digit with LATCH asserted: reset wins, snapshot cleared
      clk1();
      bus.BCD_IN = 16'h9999;
      bus.OVF    = 1'b1;
      bus.LATCH  = 1'b1;
      RST        = 1'b1;
      clk1();
      check("mid_rst_seg", 32'(bus.SEG), 32'h00);
      check("mid_rst_dig", 32'(bus.DIG), 32'hF);
      check("mid_rst_tick", 32'(bus.SCAN_TICK), 32'h0);
      RST       = 1'b0;
      bus.LATCH = 1'b0;
      bus.OVF   = 1'b0;
      n = 0;
      clk1();
      check("post_rst_seg", 32'(bus.SEG), 32'h3F);
      check("post_rst_dig", 32'(bus.DIG), 32'b1110);

      // leading-zero handling (blanked only when the option is built in)
      latch_pulse(16'h0050, 1'b0);
`ifdef SEG7_SCAN_LZB_EN
      e = {8'h00, 8'h00, 8'h6D, 8'h3F};
`else
      e = {8'h3F, 8'h3F, 8'h6D, 8'h3F};
`endif
      check_scan("lz0050", e);
      latch_pulse(16'h0000, 1'b1);
`ifdef SEG7_SCAN_LZB_EN
      e = {8'h80, 8'h80, 8'h80, 8'hBF};
`else
      e = {8'hBF, 8'hBF, 8'hBF, 8'hBF};
`endif
      check_scan("lz0000", e);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
